bus_xfer_ctrl: RTL

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_xfer_ctrl_if.sv | 28 ++
 rtl/bus_xfer_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_xfer_ctrl_if : command, bus-enable and memory handshake bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface bus_xfer_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  src_sel;
   logic [4:0]  dst_sel;
   logic [19:0] src_out;
   logic [18:0] dst_in;
   logic        mem_rd;
   logic        mem_ready;
   logic        done;
   logic        err;

   modport slave (
      input  cmd_valid, src_sel, dst_sel, mem_ready,
      output cmd_ready, src_out, dst_in, mem_rd, done, err
   );

   modport master (
      output cmd_valid, src_sel, dst_sel, mem_ready,
      input  cmd_ready, src_out, dst_in, mem_rd, done, err
   );
endinterface
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_xfer_ctrl : sequences one register-bus transfer (drive, then capture)
// Revision: 1.0
// ----------------------------------------------------------------------------
module bus_xfer_ctrl (
   input  logic            clock,
   input  logic            clear,
   bus_xfer_ctrl_if.slave  bus
);
   localparam logic [4:0] SRC_MAX   = 5'd19;
   localparam logic [4:0] DST_MAX   = 5'd18;
   localparam logic [4:0] MDR_CODE  = 5'd18;
   localparam logic [3:0] WAIT_LAST = 4'd14;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MEMWAIT = 3'd1,
      DRIVE   = 3'd2,
      CAPTURE = 3'd3,
      ERR     = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  src_q, src_nxt;
   logic [4:0]  dst_q, dst_nxt;
   logic [3:0]  cnt, cnt_nxt;

   logic        cmd_ready_q, cmd_ready_d;
   logic [19:0] src_out_q, src_out_d;
   logic [18:0] dst_in_q, dst_in_d;
   logic        mem_rd_q, mem_rd_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   always_ff @(posedge clock) begin
      if (clear) begin
         state       <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         cnt         <= '0;
         cmd_ready_q <= 1'b1;
         src_out_q   <= '0;
         dst_in_q    <= '0;
         mem_rd_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_nxt;
         src_q       <= src_nxt;
         dst_q       <= dst_nxt;
         cnt         <= cnt_nxt;
         cmd_ready_q <= cmd_ready_d;
         src_out_q   <= src_out_d;
         dst_in_q    <= dst_in_d;
         mem_rd_q    <= mem_rd_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_nxt = state;
      src_nxt   = src_q;
      dst_nxt   = dst_q;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               src_nxt = bus.src_sel;
               dst_nxt = bus.dst_sel;
               cnt_nxt = '0;
               if (bus.src_sel > SRC_MAX || bus.dst_sel > DST_MAX)
                  state_nxt = ERR;
               else if (bus.src_sel == MDR_CODE)
                  state_nxt = MEMWAIT;
               else
                  state_nxt = DRIVE;
            end
         end
         // Data arriving on the last wait cycle still beats the timeout.
         MEMWAIT: begin
            if (bus.mem_ready)
               state_nxt = DRIVE;
            else if (cnt == WAIT_LAST)
               state_nxt = ERR;
            else
               cnt_nxt = cnt + 4'd1;
         end
         DRIVE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Outputs are decoded from the upcoming state so they leave flops.
      cmd_ready_d = (state_nxt == IDLE);
      mem_rd_d    = (state_nxt == MEMWAIT);
      done_d      = (state_nxt == CAPTURE);
      err_d       = (state_nxt == ERR);
      src_out_d   = '0;
      dst_in_d    = '0;
      if (state_nxt == DRIVE || state_nxt == CAPTURE)
         src_out_d = 20'd1 << src_nxt;
      if (state_nxt == CAPTURE)
         dst_in_d = 19'd1 << dst_nxt;
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.src_out   = src_out_q;
   assign bus.dst_in    = dst_in_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule
`default_nettype wire
